// File: rtl/lg_cmd_seq.sv
// Command FIFO plus IDLE/ISSUE/HOLD sequencer that drives an external combinational gate unit.
// Optional result checker enabled by defining LG_CMD_CHECK_EN.
module lg_cmd_seq #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_mode,
  input  logic [3:0]                 in_a,
  input  logic [3:0]                 in_b,
  output logic [2:0]                 lg_mode,
  output logic [3:0]                 lg_a,
  output logic [3:0]                 lg_b,
  input  logic [3:0]                 lg_y,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2:0]                 out_mode,
  output logic [3:0]                 out_a,
  output logic [3:0]                 out_b,
  output logic [3:0]                 out_y,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       mismatch
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t         state_r, state_s;
  logic [10:0]    mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]  count_r;
  logic [10:0]    issue_r;
  logic [3:0]     y_r;
  logic           push_s, pop_s, capture_s;

  assign in_ready   = (count_r < DEPTH_C);
  assign push_s     = in_valid && in_ready;
  assign fifo_count = count_r;

  assign out_valid  = (state_r == HOLD);
  assign out_mode   = issue_r[10:8];
  assign out_a      = issue_r[7:4];
  assign out_b      = issue_r[3:0];
  assign out_y      = y_r;
  assign lg_mode    = (state_r == IDLE) ? 3'd0 : issue_r[10:8];
  assign lg_a       = (state_r == IDLE) ? 4'd0 : issue_r[7:4];
  assign lg_b       = (state_r == IDLE) ? 4'd0 : issue_r[3:0];

  // Next-state and pop/capture decisions.
  always_comb begin
    state_s   = state_r;
    pop_s     = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (count_r != {CW{1'b0}}) begin
          pop_s   = 1'b1;
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        capture_s = 1'b1;
        state_s   = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          if (count_r != {CW{1'b0}}) begin
            pop_s   = 1'b1;
            state_s = ISSUE;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Command storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {in_mode, in_a, in_b};
    end
  end

  // State, pointers, occupancy, issue register and captured result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      issue_r  <= 11'd0;
      y_r      <= 4'd0;
    end else begin
      state_r <= state_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        issue_r  <= mem_r[rd_ptr_r];
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      // Occupancy only moves when exactly one side of the FIFO is active.
      if (push_s && !pop_s) begin
        count_r <= count_r + CW'(1);
      end else if (pop_s && !push_s) begin
        count_r <= count_r - CW'(1);
      end
      if (capture_s) begin
        y_r <= lg_y;
      end
    end
  end

`ifdef LG_CMD_CHECK_EN
  function automatic logic [3:0] gate_ref(input logic [2:0] m, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    case (m)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = ~a;
      3'd3:    r = ~(a & b);
      3'd4:    r = ~(a | b);
      3'd5:    r = a ^ b;
      3'd6:    r = ~(a ^ b);
      3'd7:    r = b;
      default: r = 4'd0;
    endcase
    return r;
  endfunction

  logic mismatch_r;

  // Sticky flag: set when the gate unit disagrees with the opcode table at the ISSUE edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_r <= 1'b0;
    end else if (capture_s && (lg_y != gate_ref(issue_r[10:8], issue_r[7:4], issue_r[3:0]))) begin
      mismatch_r <= 1'b1;
    end
  end

  assign mismatch = mismatch_r;
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_lg_cmd_seq.sv
// Self-checking bench for lg_cmd_seq: directed table/sequence tests plus a randomized run
// compared every cycle against a queue-based reference model.
module tb_lg_cmd_seq;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready, mismatch;
  logic [2:0] in_mode, lg_mode, out_mode;
  logic [3:0] in_a, in_b, lg_a, lg_b, lg_y, out_a, out_b, out_y;
  logic [2:0] fifo_count;
  logic       force_bad = 1'b0;
  logic       mon_on = 1'b0;

  int tests = 0;
  int fails = 0;

  lg_cmd_seq #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_a(in_a), .in_b(in_b),
    .lg_mode(lg_mode), .lg_a(lg_a), .lg_b(lg_b), .lg_y(lg_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mode(out_mode), .out_a(out_a), .out_b(out_b), .out_y(out_y),
    .fifo_count(fifo_count), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] gate(input logic [2:0] m, input logic [3:0] a, input logic [3:0] b);
    case (m)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~a;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return a ^ b;
      3'd6:    return ~(a ^ b);
      default: return b;
    endcase
  endfunction

  function automatic logic [3:0] gate_c(input logic [10:0] c);
    return gate(c[10:8], c[7:4], c[3:0]);
  endfunction

  // Downstream gate unit, optionally broken to exercise the checker.
  assign lg_y = force_bad ? 4'd0 : gate(lg_mode, lg_a, lg_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending queue plus one held command that is first issued, then shown.
  logic [10:0] q[$];
  logic [10:0] cur = 11'd0;
  logic [3:0]  y_exp = 4'd0;
  bit          have = 1'b0, shown = 1'b0, m_mis = 1'b0;

  always @(posedge clk) begin
    bit         do_pop;
    bit         do_push;
    logic [3:0] seen_y;
    if (rst) begin
      q.delete();
      have = 1'b0; shown = 1'b0; m_mis = 1'b0; cur = 11'd0; y_exp = 4'd0;
    end else begin
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = 1'b0;
      if (have && !shown) begin
        seen_y = force_bad ? 4'd0 : gate_c(cur);
        y_exp  = seen_y;
        shown  = 1'b1;
`ifdef LG_CMD_CHECK_EN
        if (seen_y != gate_c(cur)) m_mis = 1'b1;
`endif
      end else if (have) begin
        if (out_ready) begin
          have = 1'b0;
          do_pop = (q.size() > 0);
        end
      end else begin
        do_pop = (q.size() > 0);
      end
      if (do_pop) begin
        cur = q.pop_front();
        have = 1'b1;
        shown = 1'b0;
      end
      if (do_push) q.push_back({in_mode, in_a, in_b});
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (mon_on) begin
      check("fifo_count", fifo_count, q.size());
      check("in_ready", in_ready, (q.size() < DEPTH));
      check("out_valid", out_valid, (have && shown));
      check("lg_cmd", {lg_mode, lg_a, lg_b}, have ? cur : 11'd0);
      check("mismatch", mismatch, m_mis);
      if (have && shown) check("out_cmd", {out_mode, out_a, out_b, out_y}, {cur, y_exp});
    end
  end

  // Results actually handed to the consumer, in order.
  logic [14:0] got[$];
  always @(negedge clk) begin
    if (mon_on && !rst && out_valid && out_ready) got.push_back({out_mode, out_a, out_b, out_y});
  end

  typedef struct {
    logic [2:0] mode;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] y;
  } vec_t;

  vec_t tbl[8];
  logic [10:0] bp_cmds[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm, input int lim);
    int n = 0;
    while (!out_valid && n < lim) begin
      tick();
      n++;
    end
    check(nm, out_valid, 1);
  endtask

  task automatic wait_results(input string nm, input int want, input int lim);
    int n = 0;
    while (got.size() < want && n < lim) begin
      tick();
      n++;
    end
    check(nm, got.size(), want);
  endtask

  task automatic push_one(input logic [2:0] m, input logic [3:0] a, input logic [3:0] b);
    bit acc = 1'b0;
    int n = 0;
    in_valid = 1'b1; in_mode = m; in_a = a; in_b = b;
    while (!acc && n < 50) begin
      acc = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("push_accepted", acc, 1);
  endtask

  initial begin
    int acc;
    logic [2:0] exp_mis;
    tbl[0] = '{3'd0, 4'd9,  4'd8,  4'd8};
    tbl[1] = '{3'd1, 4'd11, 4'd2,  4'd11};
    tbl[2] = '{3'd2, 4'd9,  4'd12, 4'd6};
    tbl[3] = '{3'd3, 4'd12, 4'd2,  4'd15};
    tbl[4] = '{3'd4, 4'd11, 4'd0,  4'd4};
    tbl[5] = '{3'd5, 4'd1,  4'd11, 4'd10};
    tbl[6] = '{3'd6, 4'd2,  4'd10, 4'd7};
    tbl[7] = '{3'd7, 4'd9,  4'd8,  4'd8};

    rst = 1'b1; in_valid = 1'b0; in_mode = 3'd0; in_a = 4'd0; in_b = 4'd0; out_ready = 1'b0;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_lg", {lg_mode, lg_a, lg_b}, 0);
    check("rst_out", {out_mode, out_a, out_b, out_y}, 0);
    check("rst_mismatch", mismatch, 0);
    rst = 1'b0;
    mon_on = 1'b1;
    check("rst_in_ready", in_ready, 1);

    // Single op latency: push at E0, result visible after E2.
    out_ready = 1'b1;
    in_valid = 1'b1; in_mode = 3'd0; in_a = 4'd9; in_b = 4'd8;
    tick();
    in_valid = 1'b0;
    check("lat_e0_count", fifo_count, 1);
    check("lat_e0_valid", out_valid, 0);
    tick();
    check("lat_e1_valid", out_valid, 0);
    tick();
    check("lat_e2_valid", out_valid, 1);
    check("lat_e2_y", out_y, 8);
    tick();
    check("lat_idle_valid", out_valid, 0);
    check("lat_idle_lg", {lg_mode, lg_a, lg_b}, 0);

    // Opcode sweep from the table, results in order.
    got.delete();
    for (int i = 0; i < 8; i++) push_one(tbl[i].mode, tbl[i].a, tbl[i].b);
    wait_results("sweep_count", 8, 100);
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      check($sformatf("sweep_cmd%0d", i), got[i][14:4], {tbl[i].mode, tbl[i].a, tbl[i].b});
      check($sformatf("sweep_y%0d", i), got[i][3:0], tbl[i].y);
    end
    tick(); tick();

    // Backpressure: six offers, five accepted.
    out_ready = 1'b0;
    acc = 0;
    bp_cmds.delete();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_mode = 3'(i); in_a = 4'(i + 3); in_b = 4'(14 - i);
      if (in_ready) begin
        acc++;
        bp_cmds.push_back({in_mode, in_a, in_b});
      end
      tick();
    end
    in_valid = 1'b0;
    check("bp_accepted", acc, 5);
    check("bp_fifo_count", fifo_count, 4);
    check("bp_in_ready", in_ready, 0);
    got.delete();
    out_ready = 1'b1;
    wait_results("bp_results", 5, 100);
    for (int i = 0; i < 5 && i < got.size() && i < bp_cmds.size(); i++)
      check($sformatf("bp_order%0d", i), got[i], {bp_cmds[i], gate_c(bp_cmds[i])});
    check("bp_drained", fifo_count, 0);
    tick(); tick();

    // Reset while holding a result with three queued.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_mode = 3'd5; in_a = 4'(i); in_b = 4'd6;
      tick();
    end
    in_valid = 1'b0;
    check("mid_count", fifo_count, 3);
    check("mid_valid", out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_in_ready", in_ready, 1);
    got.delete();
    out_ready = 1'b1;
    repeat (10) tick();
    check("mid_no_results", got.size(), 0);

    // Checker: faulty gate result for OR 11,2, then a correct op.
`ifdef LG_CMD_CHECK_EN
    exp_mis = 3'd1;
`else
    exp_mis = 3'd0;
`endif
    force_bad = 1'b1;
    push_one(3'd1, 4'd11, 4'd2);
    wait_valid("chk_valid", 20);
    check("chk_bad_y", out_y, 0);
    check("chk_mismatch_set", mismatch, exp_mis);
    force_bad = 1'b0;
    tick();
    push_one(3'd5, 4'd3, 4'd5);
    wait_valid("chk_valid2", 20);
    check("chk_good_y", out_y, 6);
    check("chk_mismatch_sticky", mismatch, exp_mis);
    tick();

    // Randomized traffic checked cycle by cycle against the model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_mode   = 3'($urandom_range(0, 7));
      in_a      = 4'($urandom_range(0, 15));
      in_b      = 4'($urandom_range(0, 15));
      out_ready = (c % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      force_bad = ($urandom_range(0, 29) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end
    in_valid = 1'b0; rst = 1'b0; force_bad = 1'b0; out_ready = 1'b1;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
